// File: rtl/demux8_rr_sched_if.sv
// Handshake and demux-control bundle between the round-robin scheduler and
// its sinks/source. The master side is the scheduler; the slave side is the environment.
interface demux8_rr_sched_if;
    logic [7:0] req;
    logic       d_valid;
    logic       d_ready;
    logic       e;
    logic [2:0] s;
    logic [7:0] grant;
    logic       busy;

    modport master (
        input  req,
        input  d_valid,
        output d_ready,
        output e,
        output s,
        output grant,
        output busy
    );

    modport slave (
        output req,
        output d_valid,
        input  d_ready,
        input  e,
        input  s,
        input  grant,
        input  busy
    );
endinterface

// File: rtl/demux8_rr_sched.sv
// Round-robin scheduler driving a 1-to-8 demux with a one-cycle break-before-make gap.
// Optional idle-beat timeout per grant: define DEMUX8_SCHED_TIMEOUT_EN.
module demux8_rr_sched #(
    parameter int DWELL   = 4,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    demux8_rr_sched_if.master      bus
`ifdef DEMUX8_SCHED_TIMEOUT_EN
    ,
    output logic                   timeout_evt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    state_e           state_q, state_d;
    logic [2:0]       s_q, s_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             beat;

`ifdef DEMUX8_SCHED_TIMEOUT_EN
    localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT - 1);

    logic [7:0] idle_q, idle_d;
    logic       tout_q, tout_d;
`endif

    // Scan upward from ptr+1; descending loop lets the nearest requester win,
    // and k=8 lands on ptr itself so a sole last-served requester is re-granted.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] idx;
        logic [2:0] w;
        w = p;
        for (int k = 8; k >= 1; k--) begin
            idx = p + 3'(k);
            if (r[idx]) w = idx;
        end
        return w;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            s_q     <= 3'd0;
            ptr_q   <= 3'd7;
            cnt_q   <= '0;
`ifdef DEMUX8_SCHED_TIMEOUT_EN
            idle_q  <= 8'd0;
            tout_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
`ifdef DEMUX8_SCHED_TIMEOUT_EN
            idle_q  <= idle_d;
            tout_q  <= tout_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        beat    = 1'b0;
`ifdef DEMUX8_SCHED_TIMEOUT_EN
        idle_d  = idle_q;
        tout_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    s_d     = rr_pick(bus.req, ptr_q);
                    cnt_d   = '0;
                    state_d = SERVE;
`ifdef DEMUX8_SCHED_TIMEOUT_EN
                    idle_d  = 8'd0;
`endif
                end
            end
            SERVE: begin
                beat = bus.d_valid;
                if (beat) cnt_d = cnt_q + 1'b1;
`ifdef DEMUX8_SCHED_TIMEOUT_EN
                idle_d = beat ? 8'd0 : idle_q + 8'd1;
`endif
                // A beat coinciding with the req drop was already routed; just leave.
                if (!bus.req[s_q] || (beat && cnt_q == CNT_LAST)) begin
                    state_d = GAP;
                    ptr_d   = s_q;
                    cnt_d   = '0;
                end
`ifdef DEMUX8_SCHED_TIMEOUT_EN
                else if (!beat && idle_q == IDLE_LAST) begin
                    state_d = GAP;
                    ptr_d   = s_q;
                    cnt_d   = '0;
                    tout_d  = 1'b1;
                end
`endif
            end
            GAP: begin
                if (|bus.req) begin
                    s_d     = rr_pick(bus.req, ptr_q);
                    cnt_d   = '0;
                    state_d = SERVE;
`ifdef DEMUX8_SCHED_TIMEOUT_EN
                    idle_d  = 8'd0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode registered state only.
    assign bus.e       = (state_q == SERVE);
    assign bus.d_ready = (state_q == SERVE);
    assign bus.s       = s_q;
    assign bus.grant   = (state_q == SERVE) ? (8'd1 << s_q) : 8'd0;
    assign bus.busy    = (state_q != IDLE);

`ifdef DEMUX8_SCHED_TIMEOUT_EN
    assign timeout_evt_o = tout_q;
`endif

endmodule

// File: doc/demux8_rr_sched.md
Name: demux8_rr_sched

Overview:
- Round-robin scheduler for the 1-to-8 enabled demultiplexer (enable e, 3-bit select s).
- Shares one serial data source between 8 requesting sink channels.
- Grants one channel at a time for up to DWELL accepted beats, and drives the demux enable/select from registered state.
- Inserts a one-cycle break-before-make gap between grants, so no beat is routed while the select is changing.

Parameters:
- DWELL, 4, maximum accepted beats per grant; legal range 1..255.
- CNT_W, 8, beat counter width; must satisfy 2^CNT_W > DWELL.
- TIMEOUT, 16, idle-beat limit per grant; used only when DEMUX8_SCHED_TIMEOUT_EN is defined; legal range 1..255.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  8  per-channel request; bit i = sink i wants data.
- d_valid  input  1  source has a beat this cycle.
- d_ready  output  1  scheduler accepts a beat this cycle (beat = d_valid & d_ready).
- e  output  1  demux enable.
- s  output  3  demux select = granted channel index.
- grant  output  8  one-hot grant; equals (1<<s) when e=1, else 0.
- busy  output  1  high whenever state != IDLE.
- timeout_evt  output  1  present only with DEMUX8_SCHED_TIMEOUT_EN; one-cycle pulse.

Behaviour:
- All outputs are decoded from registered state; there is no combinational path from req or d_valid to any output.
- Reset (sync, rst=1 at edge):
  - state=IDLE, e=0, s=0, grant=0, d_ready=0, busy=0, beat counter cnt=0.
  - Round-robin pointer ptr=7, so the first search starts at channel 0.
- Arbitration function (winner):
  - Scan req starting at (ptr+1) mod 8, wrapping; first set bit wins.
  - The last-served channel therefore has lowest priority.
  - If it is the only requester, it is re-granted.
- IDLE:
  - e=0, d_ready=0.
  - If req!=0 at the edge: s<=winner, cnt<=0, next SERVE.
  - Latency: req asserted in cycle N gives e=1 in cycle N+1.
- SERVE:
  - e=1, d_ready=1, grant=1<<s.
  - On each beat: cnt<=cnt+1.
  - Exit to GAP at the edge where either:
    - a beat is accepted with cnt==DWELL-1, or
    - req[s]==0.
  - On exit: ptr<=s, cnt<=0.
  - Simultaneous beat and req[s] drop: the beat counts as delivered (already routed), then exit to GAP.
  - req bits of non-granted channels have no effect while in SERVE.
- GAP:
  - Exactly one cycle; e=0, d_ready=0, grant=0.
  - If req!=0: s<=winner (using the updated ptr), cnt<=0, next SERVE.
  - Otherwise next IDLE; s holds its last value.
- DWELL=1: every accepted beat ends the grant.
- d_valid=0 in SERVE: stay in SERVE with no count while req[s] stays high (unless the timeout feature fires).
- Reset mid-operation (any state): next cycle IDLE with reset values; any partially served grant is abandoned and ptr returns to 7.
- Counter never wraps: the maximum value reached is DWELL-1 before it is cleared.

Optional Feature:
- Macro: DEMUX8_SCHED_TIMEOUT_EN.
- Defined:
  - An idle counter (reset 0) counts consecutive SERVE cycles with no beat.
  - It clears on any beat and on entry to SERVE.
  - When it reaches TIMEOUT while still in SERVE with req[s]=1, the grant ends: ptr<=s, next GAP.
  - timeout_evt=1 for the first GAP cycle only; otherwise 0.
  - A beat in the same cycle as the limit clears the counter, so no timeout occurs.
- Not defined: no idle counter and no timeout_evt port; a granted channel with no beats holds the demux indefinitely while its req stays high.

Test Plan:
1. rst=1 for 2 cycles, req=8'hFF -> while in reset and on the first cycle after release: e=0, s=0, grant=0, busy=0, d_ready=0. The second cycle after release: e=1, s=0.
2. DWELL=4, req=8'h01, d_valid=1 constant ->
   - e=1, s=0, grant=8'h01 for 4 cycles;
   - 1 GAP cycle with e=0;
   - re-grant s=0; pattern repeats with period 5.
3. After reset, req=8'h81, d_valid=1 -> grant sequence 8'h01 (4 beats), gap, 8'h80 (4 beats), gap, 8'h01; busy stays 1 throughout.
4. ptr=1, req=8'h24 -> s=2 first. Then req=8'h20 after 2 beats with d_valid=0 -> GAP next cycle, then s=5 with cnt=0.
5. In SERVE with s=3, cnt=1: d_valid=1 and req[3] falls in the same cycle -> that beat is routed to y[3], next cycle GAP, cnt=0, ptr=3.
6. rst pulsed during SERVE with s=6, cnt=2, req=8'h41 held -> next cycle IDLE with e=0; following cycle s=0, not 6.
7. With DEMUX8_SCHED_TIMEOUT_EN, TIMEOUT=16, req=8'h02, d_valid=0 -> e=1 for 16 cycles, then GAP with timeout_evt=1 for one cycle, then re-grant s=1.
